// File: rtl/axi4l_parity_pkg.sv
// Shared constants, FSM state types and a byte-strobe helper for the
// AXI4-Lite parity register slave.
package axi4l_parity_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned STRB_W   = DATA_W / 8;
    localparam int unsigned NUM_DATA = 4;
    localparam int unsigned PAR_W    = NUM_DATA + 1;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned ADDR_LSB = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Register byte offsets
    localparam logic [ADDR_W-1:0] OFF_DATA0  = 5'h00;
    localparam logic [ADDR_W-1:0] OFF_DATA1  = 5'h04;
    localparam logic [ADDR_W-1:0] OFF_DATA2  = 5'h08;
    localparam logic [ADDR_W-1:0] OFF_DATA3  = 5'h0C;
    localparam logic [ADDR_W-1:0] OFF_PARITY = 5'h10;
    localparam logic [ADDR_W-1:0] OFF_CTRL   = 5'h14;
    localparam logic [ADDR_W-1:0] OFF_WCOUNT = 5'h18;
    localparam logic [ADDR_W-1:0] OFF_ID     = 5'h1C;

    localparam logic [DATA_W-1:0] ID_DEFAULT = 32'h50415231;

    typedef enum logic {
        W_IDLE = 1'b0,
        W_RESP = 1'b1
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Merge new_v into old_v on the byte lanes enabled by strb.
    function automatic logic [DATA_W-1:0] apply_wstrb(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [STRB_W-1:0] strb
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/parity_reduce.sv
// Combinational parity word generator.
//   data_i   : four 32-bit data words
//   odd_i    : 1 selects odd parity (every bit inverted)
//   parity_c : [i] = parity of word i, [4] = parity of all four words
module parity_reduce
    import axi4l_parity_pkg::*;
(
    input  logic [NUM_DATA-1:0][DATA_W-1:0] data_i,
    input  logic                            odd_i,
    output logic [PAR_W-1:0]                parity_c
);

    always_comb begin
        parity_c = '0;
        for (int unsigned i = 0; i < NUM_DATA; i++) begin
            parity_c[i] = (^data_i[i]) ^ odd_i;
        end
        parity_c[NUM_DATA] = (^data_i) ^ odd_i;
    end

endmodule

// File: rtl/axi4l_parity_slave.sv
// AXI4-Lite slave with four RW data words, a parity status word, a parity
// control bit, a write counter and a constant ID word.
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*  : write address / data channels (captured independently)
//   S_AXI_B*              : write response (OKAY, or SLVERR for RO offsets)
//   S_AXI_AR* / S_AXI_R*  : read address / data channels (RRESP always OKAY)
// All outputs are registered; none depends on same-cycle VALID inputs.
module axi4l_parity_slave
    import axi4l_parity_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 5,
    parameter logic [31:0] C_ID_VALUE         = ID_DEFAULT
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY
);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    wr_state_e                       wstate_q,  wstate_d;
    logic                            awready_q, awready_d;
    logic                            wready_q,  wready_d;
    logic                            bvalid_q,  bvalid_d;
    logic [1:0]                      bresp_q,   bresp_d;
    logic                            aw_held_q, aw_held_d;
    logic                            w_held_q,  w_held_d;
    logic [IDX_W-1:0]                aw_idx_q,  aw_idx_d;
    logic [DATA_W-1:0]               wdata_q,   wdata_d;
    logic [STRB_W-1:0]               wstrb_q,   wstrb_d;

    rd_state_e                       rstate_q,  rstate_d;
    logic                            arready_q, arready_d;
    logic                            rvalid_q,  rvalid_d;
    logic [DATA_W-1:0]               rdata_q,   rdata_d;

    logic [NUM_DATA-1:0][DATA_W-1:0] data_q,    data_d;
    logic                            ctrl_q,    ctrl_d;
    logic [DATA_W-1:0]               wcount_q,  wcount_d;

    // ---------------------------------------------------------------
    // Combinational helpers
    // ---------------------------------------------------------------
    logic              aw_hs, w_hs, ar_hs;
    logic              aw_have, w_have;
    logic [IDX_W-1:0]  commit_idx;
    logic [DATA_W-1:0] commit_data;
    logic [STRB_W-1:0] commit_strb;
    logic [PAR_W-1:0]  parity;
    logic [DATA_W-1:0] rd_word;

    // Protection bits, address byte lanes and any upper address bits carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR, S_AXI_ARADDR};

    assign aw_hs   = S_AXI_AWVALID & awready_q;
    assign w_hs    = S_AXI_WVALID  & wready_q;
    assign ar_hs   = S_AXI_ARVALID & arready_q;
    assign aw_have = aw_held_q | aw_hs;
    assign w_have  = w_held_q  | w_hs;

    // Commit operands come from the holding registers if already captured,
    // otherwise straight from the channel handshaking this cycle.
    assign commit_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[ADDR_LSB +: IDX_W];
    assign commit_data = w_held_q  ? wdata_q  : S_AXI_WDATA;
    assign commit_strb = w_held_q  ? wstrb_q  : S_AXI_WSTRB;

    parity_reduce u_parity (
        .data_i   (data_q),
        .odd_i    (ctrl_q),
        .parity_c (parity)
    );

    // Read mux over the current (pre-commit) register state.
    always_comb begin
        rd_word = '0;
        case ({S_AXI_ARADDR[ADDR_LSB +: IDX_W], 2'b00})
            OFF_DATA0:  rd_word = data_q[0];
            OFF_DATA1:  rd_word = data_q[1];
            OFF_DATA2:  rd_word = data_q[2];
            OFF_DATA3:  rd_word = data_q[3];
            OFF_PARITY: rd_word = DATA_W'(parity);
            OFF_CTRL:   rd_word = DATA_W'(ctrl_q);
            OFF_WCOUNT: rd_word = wcount_q;
            OFF_ID:     rd_word = C_ID_VALUE;
            default:    rd_word = '0;
        endcase
    end

    // ---------------------------------------------------------------
    // Write FSM, register file and write counter
    // ---------------------------------------------------------------
    always_comb begin
        wstate_d  = wstate_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        aw_idx_d  = aw_idx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        data_d    = data_q;
        ctrl_d    = ctrl_q;
        wcount_d  = wcount_q;

        case (wstate_q)
            W_IDLE: begin
                if (aw_have && w_have) begin
                    wstate_d  = W_RESP;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    bresp_d   = RESP_OKAY;
                    wcount_d  = wcount_q + DATA_W'(1);
                    case ({commit_idx, 2'b00})
                        OFF_DATA0, OFF_DATA1, OFF_DATA2, OFF_DATA3: begin
                            data_d[commit_idx[1:0]] = apply_wstrb(
                                data_q[commit_idx[1:0]], commit_data, commit_strb);
                        end
                        OFF_CTRL: begin
                            if (commit_strb[0]) begin
                                ctrl_d = commit_data[0];
                            end
                        end
                        default: begin
                            // Read-only offsets: reject without side effects.
                            bresp_d  = RESP_SLVERR;
                            wcount_d = wcount_q;
                        end
                    endcase
                end else begin
                    if (aw_hs) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = S_AXI_AWADDR[ADDR_LSB +: IDX_W];
                    end
                    if (w_hs) begin
                        w_held_d = 1'b1;
                        wdata_d  = S_AXI_WDATA;
                        wstrb_d  = S_AXI_WSTRB;
                    end
                    // Each channel stays open until its beat is held.
                    awready_d = ~aw_have;
                    wready_d  = ~w_have;
                end
            end
            W_RESP: begin
                if (S_AXI_BREADY) begin
                    wstate_d  = W_IDLE;
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                end
            end
            default: begin
                wstate_d = W_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Read FSM
    // ---------------------------------------------------------------
    always_comb begin
        rstate_d  = rstate_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;

        case (rstate_q)
            R_IDLE: begin
                if (ar_hs) begin
                    rstate_d  = R_DATA;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rdata_d   = rd_word;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (S_AXI_RREADY) begin
                    rstate_d  = R_IDLE;
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                end
            end
            default: begin
                rstate_d = R_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // State registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            wstate_q  <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_idx_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rstate_q  <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            data_q    <= '0;
            ctrl_q    <= 1'b0;
            wcount_q  <= '0;
        end else begin
            wstate_q  <= wstate_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            aw_idx_q  <= aw_idx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rstate_q  <= rstate_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            wcount_q  <= wcount_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;

endmodule

// File: tb/tb_axi4l_parity_slave.sv
// Directed self-checking bench for axi4l_parity_slave.
module tb_axi4l_parity_slave;

    localparam int LIMIT = 20;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  S_AXI_AWADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [4:0]  S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_ARPROT = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;

    int total = 0;
    int bad   = 0;
    int wcount_exp = 0;

    axi4l_parity_slave dut (
        .clock         (clock),
        .reset         (reset),
        .S_AXI_AWADDR  (S_AXI_AWADDR),
        .S_AXI_AWPROT  (S_AXI_AWPROT),
        .S_AXI_AWVALID (S_AXI_AWVALID),
        .S_AXI_AWREADY (S_AXI_AWREADY),
        .S_AXI_WDATA   (S_AXI_WDATA),
        .S_AXI_WSTRB   (S_AXI_WSTRB),
        .S_AXI_WVALID  (S_AXI_WVALID),
        .S_AXI_WREADY  (S_AXI_WREADY),
        .S_AXI_BRESP   (S_AXI_BRESP),
        .S_AXI_BVALID  (S_AXI_BVALID),
        .S_AXI_BREADY  (S_AXI_BREADY),
        .S_AXI_ARADDR  (S_AXI_ARADDR),
        .S_AXI_ARPROT  (S_AXI_ARPROT),
        .S_AXI_ARVALID (S_AXI_ARVALID),
        .S_AXI_ARREADY (S_AXI_ARREADY),
        .S_AXI_RDATA   (S_AXI_RDATA),
        .S_AXI_RRESP   (S_AXI_RRESP),
        .S_AXI_RVALID  (S_AXI_RVALID),
        .S_AXI_RREADY  (S_AXI_RREADY)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp,
                             output int lat);
        logic aw_p, w_p, aw_h, w_h;
        int n;
        S_AXI_AWADDR  = addr;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WDATA   = data;
        S_AXI_WSTRB   = strb;
        S_AXI_WVALID  = 1'b1;
        aw_p = 1'b1;
        w_p  = 1'b1;
        n    = 0;
        while ((aw_p || w_p) && n < LIMIT) begin
            aw_h = aw_p & S_AXI_AWREADY;
            w_h  = w_p  & S_AXI_WREADY;
            tick();
            if (aw_h) begin aw_p = 1'b0; S_AXI_AWVALID = 1'b0; end
            if (w_h)  begin w_p  = 1'b0; S_AXI_WVALID  = 1'b0; end
            n++;
        end
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("wr_handshake_pending", {30'd0, aw_p, w_p}, 32'd0);
        lat = 0;
        while (!S_AXI_BVALID && lat < LIMIT) begin
            tick();
            lat++;
        end
        chk("wr_bvalid", 32'(S_AXI_BVALID), 32'd1);
        resp = S_AXI_BRESP;
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        logic hs;
        int n;
        S_AXI_ARADDR  = addr;
        S_AXI_ARVALID = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < LIMIT) begin
            hs = S_AXI_ARREADY;
            tick();
            n++;
        end
        S_AXI_ARVALID = 1'b0;
        chk("rd_ar_handshake", 32'(hs), 32'd1);
        lat = 0;
        while (!S_AXI_RVALID && lat < LIMIT) begin
            tick();
            lat++;
        end
        chk("rd_rvalid", 32'(S_AXI_RVALID), 32'd1);
        data = S_AXI_RDATA;
        resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wr_chk(input string tag, input logic [4:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_resp);
        logic [1:0] resp;
        int lat;
        axi_write(addr, data, strb, resp, lat);
        chk({tag, "_bresp"}, 32'(resp), 32'(exp_resp));
        if (exp_resp == 2'b00) wcount_exp++;
    endtask

    task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] data;
        logic [1:0]  resp;
        int lat;
        axi_read(addr, data, resp, lat);
        chk({tag, "_rdata"}, data, exp);
        chk({tag, "_rresp"}, 32'(resp), 32'd0);
    endtask

    initial begin
        logic [1:0]  resp;
        logic [31:0] rdata;
        int          lat;

        // Reset state
        repeat (3) tick();
        chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
        chk("rst_wready",  32'(S_AXI_WREADY),  32'd0);
        chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        chk("rst_bvalid",  32'(S_AXI_BVALID),  32'd0);
        chk("rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        chk("rst_rdata",   S_AXI_RDATA,        32'd0);
        chk("rst_bresp",   32'(S_AXI_BRESP),   32'd0);
        reset = 1'b0;
        tick();
        chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
        chk("post_rst_wready",  32'(S_AXI_WREADY),  32'd1);
        chk("post_rst_arready", 32'(S_AXI_ARREADY), 32'd1);

        // Basic write/read-back; first write checks AW+W same-cycle latency
        axi_write(5'h00, 32'h1, 4'hF, resp, lat);
        chk("t1_wr_latency", 32'(lat), 32'd0);
        chk("t1_wr0_bresp", 32'(resp), 32'd0);
        wcount_exp++;
        wr_chk("t1_wr1", 5'h04, 32'h2, 4'hF, 2'b00);
        wr_chk("t1_wr2", 5'h08, 32'h3, 4'hF, 2'b00);
        wr_chk("t1_wr3", 5'h0C, 32'h4, 4'hF, 2'b00);
        axi_read(5'h00, rdata, resp, lat);
        chk("t1_rd_latency", 32'(lat), 32'd0);
        chk("t1_rd0", rdata, 32'h1);
        rd_chk("t1_rd1", 5'h04, 32'h2);
        rd_chk("t1_rd2", 5'h08, 32'h3);
        rd_chk("t1_rd3", 5'h0C, 32'h4);
        rd_chk("t1_wcount", 5'h18, 32'd4);
        // ^1=1, ^2=1, ^3=0, ^4=1; all-word parity = 1 -> 5'b11011
        rd_chk("t1_parity", 5'h10, 32'h0000001B);

        // Byte-strobe merge and zero-strobe write
        wr_chk("t2_full", 5'h00, 32'hFFFFFFFF, 4'hF, 2'b00);
        wr_chk("t2_strb", 5'h00, 32'h00000A00, 4'b0010, 2'b00);
        rd_chk("t2_rd0", 5'h00, 32'hFFFF0AFF);
        wr_chk("t2_nostrb", 5'h04, 32'hDEADBEEF, 4'b0000, 2'b00);
        rd_chk("t2_rd1", 5'h04, 32'h2);
        rd_chk("t2_wcount", 5'h18, 32'd7);

        // Odd-parity select
        wr_chk("t3_ctrl1", 5'h14, 32'hFFFFFFFF, 4'hF, 2'b00);
        wr_chk("t3_d0", 5'h00, 32'h0, 4'hF, 2'b00);
        wr_chk("t3_d1", 5'h04, 32'h0, 4'hF, 2'b00);
        wr_chk("t3_d2", 5'h08, 32'h0, 4'hF, 2'b00);
        wr_chk("t3_d3", 5'h0C, 32'h0, 4'hF, 2'b00);
        rd_chk("t3_ctrl_rd", 5'h14, 32'h1);
        rd_chk("t3_par_odd", 5'h10, 32'h0000001F);
        wr_chk("t3_ctrl0", 5'h14, 32'h0, 4'hF, 2'b00);
        rd_chk("t3_par_even", 5'h10, 32'h0);

        // AW three cycles ahead of W, BREADY stalled, next AW blocked
        S_AXI_AWADDR  = 5'h04;
        S_AXI_AWVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        chk("t4_awready_held", 32'(S_AXI_AWREADY), 32'd0);
        chk("t4_wready_open",  32'(S_AXI_WREADY),  32'd1);
        chk("t4_no_bvalid",    32'(S_AXI_BVALID),  32'd0);
        tick();
        tick();
        S_AXI_WDATA  = 32'h55;
        S_AXI_WSTRB  = 4'hF;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_WVALID = 1'b0;
        chk("t4_bvalid", 32'(S_AXI_BVALID), 32'd1);
        S_AXI_AWADDR  = 5'h08;
        S_AXI_AWVALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t4_stall_bvalid",  32'(S_AXI_BVALID),  32'd1);
            chk("t4_stall_bresp",   32'(S_AXI_BRESP),   32'd0);
            chk("t4_stall_awready", 32'(S_AXI_AWREADY), 32'd0);
        end
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        chk("t4_bvalid_drop", 32'(S_AXI_BVALID),  32'd0);
        chk("t4_awready_back", 32'(S_AXI_AWREADY), 32'd1);
        S_AXI_WDATA  = 32'h66;
        S_AXI_WVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        chk("t4_second_bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("t4_second_bresp",  32'(S_AXI_BRESP),  32'd0);
        S_AXI_BREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        wcount_exp += 2;
        rd_chk("t4_rd1", 5'h04, 32'h55);
        rd_chk("t4_rd2", 5'h08, 32'h66);

        // Writes to read-only offsets
        wr_chk("t5_id_wr", 5'h1C, 32'h12345678, 4'hF, 2'b10);
        wr_chk("t5_par_wr", 5'h10, 32'hFFFFFFFF, 4'hF, 2'b10);
        rd_chk("t5_id", 5'h1C, 32'h50415231);
        rd_chk("t5_wcount", 5'h18, 32'(wcount_exp));

        // Read and write to the same register on the same edge
        S_AXI_AWADDR  = 5'h0C;
        S_AXI_WDATA   = 32'h77;
        S_AXI_WSTRB   = 4'hF;
        S_AXI_ARADDR  = 5'h0C;
        S_AXI_AWVALID = 1'b1;
        S_AXI_WVALID  = 1'b1;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_AWVALID = 1'b0;
        S_AXI_WVALID  = 1'b0;
        S_AXI_ARVALID = 1'b0;
        chk("t5b_bvalid", 32'(S_AXI_BVALID), 32'd1);
        chk("t5b_rvalid", 32'(S_AXI_RVALID), 32'd1);
        chk("t5b_rdata_old", S_AXI_RDATA, 32'h0);
        S_AXI_BREADY = 1'b1;
        S_AXI_RREADY = 1'b1;
        tick();
        S_AXI_BREADY = 1'b0;
        S_AXI_RREADY = 1'b0;
        wcount_exp++;
        rd_chk("t5b_rd3", 5'h0C, 32'h77);
        rd_chk("t5b_wcount", 5'h18, 32'(wcount_exp));

        // Reset while a read response is stalled
        S_AXI_ARADDR  = 5'h0C;
        S_AXI_ARVALID = 1'b1;
        tick();
        S_AXI_ARVALID = 1'b0;
        chk("t6_rvalid", 32'(S_AXI_RVALID), 32'd1);
        tick();
        tick();
        chk("t6_rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
        chk("t6_rdata_hold", S_AXI_RDATA, 32'h77);
        reset = 1'b1;
        tick();
        chk("t6_rst_rvalid",  32'(S_AXI_RVALID),  32'd0);
        chk("t6_rst_arready", 32'(S_AXI_ARREADY), 32'd0);
        chk("t6_rst_rdata",   S_AXI_RDATA,        32'd0);
        reset = 1'b0;
        tick();
        chk("t6_arready_back", 32'(S_AXI_ARREADY), 32'd1);
        rd_chk("t6_d3_cleared", 5'h0C, 32'h0);
        rd_chk("t6_d0_cleared", 5'h00, 32'h0);
        rd_chk("t6_wcount_cleared", 5'h18, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
